// File: rtl/fetch_prefetch_buffer_if.sv
// Signal bundle between the fetch front end, instruction memory and decode:
// redirect input, memory request/response channel and instruction delivery.
interface fetch_prefetch_buffer_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads under a credit limit, buffers the
// in-order responses with their PCs and delivers them to decode; a redirect flushes and restarts.
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                    clk,
   input  logic                    reset,
   fetch_prefetch_buffer_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;
   localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);

   logic [31:0]   fetch_pc_reg;
   logic [31:0]   rsp_pc_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] outstanding_reg;
   logic [CW-1:0] discard_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic [SW-1:0] credit_used;
   logic          req_valid;
   logic          req_fire;
   logic          rsp_accept;
   logic          push;
   logic          pop;
   logic          head_valid;
   logic          redirect_pc_unused;

   // Every in-flight request owns a FIFO slot, so the buffer can never overflow.
   assign credit_used = {1'b0, count_reg} + {1'b0, outstanding_reg};
   assign req_valid   = !reset && !bus.redirect_valid && (credit_used < DEPTH_SUM);
   assign req_fire    = req_valid && bus.imem_req_ready;
   assign rsp_accept  = bus.imem_rsp_valid && (outstanding_reg != '0);
   assign push        = !reset && rsp_accept && (discard_reg == '0) && !bus.redirect_valid;
   assign head_valid  = !reset && (count_reg != '0);
   assign pop         = head_valid && bus.inst_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = reset ? 32'h0 : fetch_pc_reg;
   assign bus.inst_valid     = head_valid;
   assign bus.inst_data      = reset ? 32'h0 : data_mem[rd_ptr_reg];
   assign bus.inst_pc        = reset ? 32'h0 : pc_mem[rd_ptr_reg];

   assign redirect_pc_unused = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         count_reg       <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
      end else begin
         outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
         if (bus.redirect_valid) begin
            fetch_pc_reg <= {bus.redirect_pc[31:2], 2'b00};
            rsp_pc_reg   <= {bus.redirect_pc[31:2], 2'b00};
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            // All requests still in flight belong to the abandoned path, including those
            // already marked stale by an earlier redirect, so the total never exceeds outstanding.
            discard_reg  <= outstanding_reg - CW'(rsp_accept);
         end else begin
            if (req_fire) begin
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (push) begin
               rsp_pc_reg <= rsp_pc_reg + 32'd4;
               wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (rsp_accept && (discard_reg != '0)) begin
               discard_reg <= discard_reg - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_reg] <= bus.imem_rsp_data;
         pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      end
   end

   // A response with nothing outstanding is a memory-side protocol violation; it is ignored.
   assert property (@(posedge clk) disable iff (reset) bus.imem_rsp_valid |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a latency-programmable memory model feeds two
// instances (RESET_PC 0 and FFFF_FFF8); accepted addresses and deliveries are logged and checked.
module tb_fetch_prefetch_buffer;
   logic        clk;
   logic        rst0;
   logic        rst1;
   logic        sel;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inst_ready;

   logic        req_valid;
   logic [31:0] req_addr;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   fetch_prefetch_buffer_if bus0();
   fetch_prefetch_buffer_if bus1();

   fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (bus0)
   );

   fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1)
   );

   assign bus0.redirect_valid = redirect_valid;
   assign bus0.redirect_pc    = redirect_pc;
   assign bus0.imem_req_ready = req_ready;
   assign bus0.imem_rsp_valid = rsp_valid;
   assign bus0.imem_rsp_data  = rsp_data;
   assign bus0.inst_ready     = inst_ready;
   assign bus1.redirect_valid = redirect_valid;
   assign bus1.redirect_pc    = redirect_pc;
   assign bus1.imem_req_ready = req_ready;
   assign bus1.imem_rsp_valid = rsp_valid;
   assign bus1.imem_rsp_data  = rsp_data;
   assign bus1.inst_ready     = inst_ready;

   assign req_valid  = sel ? bus1.imem_req_valid : bus0.imem_req_valid;
   assign req_addr   = sel ? bus1.imem_req_addr  : bus0.imem_req_addr;
   assign inst_valid = sel ? bus1.inst_valid     : bus0.inst_valid;
   assign inst_data  = sel ? bus1.inst_data      : bus0.inst_data;
   assign inst_pc    = sel ? bus1.inst_pc        : bus0.inst_pc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] acc_q[$];
   logic [31:0] del_pc[$];
   logic [31:0] del_data[$];
   int          del_cyc[$];
   int          cyc;
   int          lat;
   int          n_checks;
   int          n_pass;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One clock cycle: sample at negedge+1, then update the memory model at the next negedge.
   task automatic tick();
      logic        fire;
      logic        rsp_taken;
      logic        del;
      logic        rst_cur;
      logic [31:0] a;
      #1;
      rst_cur   = sel ? rst1 : rst0;
      fire      = req_valid && req_ready && !rst_cur;
      a         = req_addr;
      rsp_taken = rsp_valid;
      del       = inst_valid && inst_ready && !rst_cur;
      if (fire) acc_q.push_back(a);
      if (del) begin
         del_pc.push_back(inst_pc);
         del_data.push_back(inst_data);
         del_cyc.push_back(cyc);
         $display("cycle %0d: deliver pc=%h data=%h", cyc, inst_pc, inst_data);
      end
      @(posedge clk);
      @(negedge clk);
      if (rst_cur) begin
         mq.delete();
      end else begin
         if (rsp_taken && mq.size() > 0) void'(mq.pop_front());
         if (fire) mq.push_back('{addr: a, due: cyc + lat});
      end
      cyc++;
      rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
      rsp_data  = rsp_valid ? mem_word(mq[0].addr) : 32'h0;
   endtask

   task automatic do_reset();
      if (sel) rst1 = 1'b1;
      else     rst0 = 1'b1;
      redirect_valid = 1'b0;
      req_ready      = 1'b0;
      inst_ready     = 1'b0;
      tick();
      tick();
      #1;
      check("rst_req_valid",  32'(req_valid),  32'h0);
      check("rst_inst_valid", 32'(inst_valid), 32'h0);
      check("rst_req_addr",   req_addr,        32'h0);
      if (sel) rst1 = 1'b0;
      else     rst0 = 1'b0;
      acc_q.delete();
      del_pc.delete();
      del_data.delete();
      del_cyc.delete();
      cyc = 0;
   endtask

   initial begin
      logic [31:0] exp_pc;
      n_checks = 0;
      n_pass = 0;
      rst0 = 1'b1;
      rst1 = 1'b1;
      sel = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data = 32'h0;
      inst_ready = 1'b0;
      lat = 1;
      cyc = 0;
      @(negedge clk);

      // 1: streaming with a 1-cycle memory
      lat = 1;
      do_reset();
      #1;
      check("t1_first_req_valid", 32'(req_valid),  32'h1);
      check("t1_first_req_addr",  req_addr,        32'h0);
      check("t1_first_inst_vld",  32'(inst_valid), 32'h0);
      req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (8) tick();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_addr%0d", k), acc_q[k],          32'(4 * k));
         check($sformatf("t1_pc%0d", k),   del_pc[k],         32'(4 * k));
         check($sformatf("t1_cyc%0d", k),  32'(del_cyc[k]),   32'(k + 2));
         check($sformatf("t1_data%0d", k), del_data[k],       mem_word(32'(4 * k)));
      end

      // 2: decode stalled, credit limit stops fetch at DEPTH requests
      do_reset();
      req_ready = 1'b1;
      inst_ready = 1'b0;
      repeat (10) tick();
      check("t2_n_accepted", 32'(acc_q.size()), 32'd4);
      check("t2_last_addr",  acc_q[3],          32'hC);
      #1;
      check("t2_req_valid",  32'(req_valid),  32'h0);
      check("t2_inst_valid", 32'(inst_valid), 32'h1);
      check("t2_inst_pc",    inst_pc,         32'h0);
      repeat (3) tick();
      #1;
      check("t2_pc_held",    inst_pc,           32'h0);
      check("t2_data_held",  inst_data,         mem_word(32'h0));
      check("t2_n_accepted2", 32'(acc_q.size()), 32'd4);

      // 3: redirect with three reads outstanding on a 3-cycle memory
      lat = 3;
      do_reset();
      req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      check("t3_redir_noreq", 32'(req_valid), 32'h0);
      tick();
      redirect_valid = 1'b0;
      repeat (14) tick();
      check("t3_newpath_addr", acc_q[3],    32'h100);
      check("t3_pc0",          del_pc[0],   32'h100);
      check("t3_pc1",          del_pc[1],   32'h104);
      check("t3_pc2",          del_pc[2],   32'h108);
      check("t3_data0",        del_data[0], mem_word(32'h100));

      // 4: redirect coinciding with a pop and a response, unaligned target
      lat = 1;
      do_reset();
      req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (5) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      repeat (6) tick();
      check("t4_pop_pc",       del_pc[3],        32'hC);
      check("t4_pop_cyc",      32'(del_cyc[3]),  32'd5);
      check("t4_newpath_addr", acc_q[5],         32'h100);
      check("t4_first_new_pc", del_pc[4],        32'h100);
      check("t4_first_new_cyc", 32'(del_cyc[4]), 32'd8);
      check("t4_second_new_pc", del_pc[5],       32'h104);

      // 5: random back-pressure on both sides, scoreboard against +4 sequence
      lat = 2;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         req_ready = 1'($urandom);
         inst_ready = 1'($urandom);
         tick();
      end
      req_ready = 1'b0;
      inst_ready = 1'b1;
      repeat (12) tick();
      check("t5_count_match", 32'(del_pc.size()), 32'(acc_q.size()));
      exp_pc = 32'h0;
      foreach (del_pc[i]) begin
         check($sformatf("t5_pc%0d", i),   del_pc[i],   exp_pc);
         check($sformatf("t5_data%0d", i), del_data[i], mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
      end

      // 6: wrapping RESET_PC, then reset mid-stream
      rst0 = 1'b1;
      sel = 1'b1;
      lat = 1;
      do_reset();
      req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (7) tick();
      check("t6_pc0", del_pc[0], 32'hFFFF_FFF8);
      check("t6_pc1", del_pc[1], 32'hFFFF_FFFC);
      check("t6_pc2", del_pc[2], 32'h0000_0000);
      check("t6_pc3", del_pc[3], 32'h0000_0004);
      do_reset();
      req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (4) tick();
      check("t6_after_rst_pc",  del_pc[0],   32'hFFFF_FFF8);
      check("t6_after_rst_dat", del_data[0], mem_word(32'hFFFF_FFF8));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
